// File: rtl/left_shift_seq_pkg.sv
// Shared definitions for the multi-cycle left shifter/rotator: default sizes and FSM state encodings.
package left_shift_seq_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/left_shift_seq_stage.sv
// One binary-weighted stage: conditional left shift (zero fill) or left rotate by STEP bits.
module left_shift_seq_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             rot,
    output logic [WIDTH-1:0] q_c
);

    logic [WIDTH-1:0] shifted_c;

    // Bits leaving the MSB either wrap to the LSB end or are replaced by zeros.
    always_comb begin
        shifted_c = '0;
        if (rot) begin
            shifted_c = {d[WIDTH-STEP-1:0], d[WIDTH-1:WIDTH-STEP]};
        end else begin
            shifted_c = {d[WIDTH-STEP-1:0], {STEP{1'b0}}};
        end
    end

    assign q_c = en ? shifted_c : d;

endmodule

// File: rtl/left_shift_seq.sv
// Multi-cycle logical left shifter / left rotator: one weighted stage per clock,
// fixed latency over a start/done handshake.
module left_shift_seq
    import left_shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               rot,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int unsigned STAGE_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    state_e             state;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] amt;
    logic               mode;
    logic [STAGE_W-1:0] stage;

    logic [WIDTH-1:0]   stage_out_c [SHAMT_W];
    logic [WIDTH-1:0]   next_acc_c;
    logic               last_stage_c;

    // All stages evaluate the current accumulator; the stage counter picks the active one.
    for (genvar i = 0; i < int'(SHAMT_W); i++) begin : g_stage
        left_shift_seq_stage #(
            .WIDTH (WIDTH),
            .STEP  (1 << i)
        ) u_stage (
            .d   (acc),
            .en  (amt[i]),
            .rot (mode),
            .q_c (stage_out_c[i])
        );
    end

    assign next_acc_c   = stage_out_c[stage];
    assign last_stage_c = (stage == STAGE_W'(SHAMT_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            acc    <= '0;
            amt    <= '0;
            mode   <= 1'b0;
            stage  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    // A start in DONE is accepted exactly like one in IDLE (back-to-back).
                    if (start) begin
                        acc   <= A;
                        amt   <= shamt;
                        mode  <= rot;
                        stage <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    acc <= next_acc_c;
                    if (last_stage_c) begin
                        result <= next_acc_c;
                        stage  <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        stage <= stage + STAGE_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_left_shift_seq.sv
// Directed bench for left_shift_seq: table of operand/amount/mode vectors plus
// hand-written back-to-back, busy-start and mid-op reset sequences.
module tb_left_shift_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [4:0]  shamt;
    logic        rot;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total;
    int bad;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  s;
        logic        r;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    left_shift_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .shamt  (shamt),
        .rot    (rot),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one op from idle and measure latency, busy duration and the result.
    task automatic do_op(input logic [31:0] a, input logic [4:0] s, input logic r,
                         input logic [31:0] exp, input string name);
        int n;
        int busy_n;
        bit seen;
        @(negedge clk);
        A = a; shamt = s; rot = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; busy_n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            if (busy) busy_n++;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check({name, " latency"}, 32'(n), 32'd6);
        check({name, " busy_cycles"}, 32'(busy_n), 32'd5);
        check({name, " result"}, result, exp);
    endtask

    initial begin
        int n;
        int dones;
        int last_done;
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; A = '0; shamt = '0; rot = 1'b0;

        vecs[0]  = '{32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000};
        vecs[1]  = '{32'h8000_0001, 5'd4,  1'b1, 32'h0000_0018};
        vecs[2]  = '{32'h8000_0001, 5'd4,  1'b0, 32'h0000_0010};
        vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{32'h1234_5678, 5'd8,  1'b1, 32'h3456_7812};
        vecs[6]  = '{32'h1234_5678, 5'd16, 1'b0, 32'h5678_0000};
        vecs[7]  = '{32'hF000_0000, 5'd1,  1'b1, 32'hE000_0001};
        vecs[8]  = '{32'hFFFF_FFFF, 5'd31, 1'b0, 32'h8000_0000};
        vecs[9]  = '{32'hA5A5_A5A5, 5'd13, 1'b1, 32'hB4B4_B4B4};
        vecs[10] = '{32'h0000_0003, 5'd31, 1'b1, 32'h8000_0001};
        vecs[11] = '{32'h8000_0000, 5'd1,  1'b0, 32'h0000_0000};

        #3;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        #14 rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].s, vecs[i].r, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Start held high: an op every 6 cycles; A changed mid-op is not seen.
        @(negedge clk);
        A = 32'h0000_00FF; shamt = 5'd8; rot = 1'b0; start = 1'b1;
        dones = 0; last_done = 0;
        for (n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 2) A = 32'h0000_0001;
            if (done) begin
                dones++;
                check($sformatf("b2b result%0d", dones), result, 32'h0000_FF00);
                if (dones == 1) check("b2b first at", 32'(n), 32'd6);
                if (dones == 2) check("b2b period", 32'(n - last_done), 32'd6);
                last_done = n;
                A = 32'h0000_00FF;
            end
        end
        start = 1'b0;
        check("b2b done count", 32'(dones), 32'd2);
        repeat (8) @(negedge clk);

        // Start pulsed while busy is ignored.
        @(negedge clk);
        A = 32'h0000_000F; shamt = 5'd4; rot = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 32'h1234_5678; shamt = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (n = 3; n <= 16; n++) begin
            if (done) begin
                dones++;
                check("ignore latency", 32'(n), 32'd6);
                check("ignore result", result, 32'h0000_00F0);
            end
            @(negedge clk);
        end
        check("ignore done count", 32'(dones), 32'd1);
        check("ignore idle busy", 32'(busy), 32'd0);

        // Reset during SHIFT stage 2: immediate clear, no later done.
        @(negedge clk);
        A = 32'h0000_0001; shamt = 5'd3; rot = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        #4 rst = 1'b0;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst no done", 32'(dones), 32'd0);
        do_op(32'h0000_0001, 5'd3, 1'b0, 32'h0000_0008, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
